// File: rtl/regfile_writer.sv
// regfile_writer: in-order writeback queue draining onto the regfile write port,
// redirect pass-through and per-register pending scoreboard. Bypass lookup: REGFILE_WRITER_BYPASS_EN.
`ifndef REG_COUNT_L2
`define REG_COUNT_L2 4
`endif
`ifndef REG_COUNT
`define REG_COUNT 16
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
`ifndef REG_PC_INDEX
`define REG_PC_INDEX 15
`endif

`ifndef SYNTHESIS
module regfile_writer_chk #(
  parameter int N = 16
) (
  input logic         clk,
  input logic         reset,
  input logic [N-1:0] inc_err,
  input logic [N-1:0] dec_err
);
  // scoreboard counter overflow / underflow detection
  always @(posedge clk) begin
    if (!reset) begin
      assert (inc_err == {N{1'b0}}) else $error("regfile_writer: pending counter overflow, regs=%0h", inc_err);
      assert (dec_err == {N{1'b0}}) else $error("regfile_writer: pending counter underflow, regs=%0h", dec_err);
    end
  end
endmodule
`endif

module regfile_writer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [`REG_COUNT_L2-1:0] wb_addr,
  input  logic [`BIT_WIDTH-1:0]    wb_value,
  input  logic                     br_valid,
  input  logic [`BIT_WIDTH-1:0]    br_target,
  input  logic                     reserve_valid,
  input  logic [`REG_COUNT_L2-1:0] reserve_addr,
  input  logic                     flush,
  output logic                     write_enable1,
  output logic [`REG_COUNT_L2-1:0] write_addr1,
  output logic [`BIT_WIDTH-1:0]    write_value1,
  output logic                     update_pc,
  output logic [`BIT_WIDTH-1:0]    new_pc,
  output logic [`REG_COUNT-1:0]    pending,
  input  logic [`REG_COUNT_L2-1:0] fwd_addr,
  output logic                     fwd_hit,
  output logic [`BIT_WIDTH-1:0]    fwd_value
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int QCNT_W = PTR_W + 1;
  localparam logic [QCNT_W-1:0]        DEPTH_C = QCNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]         CNT_MAX = {CNT_W{1'b1}};
  localparam logic [`REG_COUNT_L2-1:0] PC_ADDR = `REG_COUNT_L2'(`REG_PC_INDEX);

  logic [`REG_COUNT_L2-1:0] addr_r  [DEPTH];
  logic [`BIT_WIDTH-1:0]    value_r [DEPTH];
  logic [PTR_W-1:0]         head_r, tail_r;
  logic [QCNT_W-1:0]        count_r;
  logic [CNT_W-1:0]         cnt_r [`REG_COUNT];

  logic                     empty_s, stall_head_s, drain_s, push_s;
  logic [`REG_COUNT_L2-1:0] head_addr_s;
  logic [`BIT_WIDTH-1:0]    head_value_s;
  logic [`REG_COUNT-1:0]    inc_s, dec_s, inc_err_s, dec_err_s;

  assign head_addr_s  = addr_r[head_r];
  assign head_value_s = value_r[head_r];

  // head presentation; a redirect holds back a PC write for one cycle
  always_comb begin
    wb_ready      = (count_r < DEPTH_C);
    empty_s       = (count_r == QCNT_W'(0));
    stall_head_s  = br_valid && (head_addr_s == PC_ADDR);
    drain_s       = !empty_s && !stall_head_s;
    push_s        = wb_valid && wb_ready && !flush;
    write_enable1 = drain_s;
    update_pc     = br_valid;
    new_pc        = br_target;
    if (drain_s) begin
      write_addr1  = head_addr_s;
      write_value1 = head_value_s;
    end else begin
      write_addr1  = `REG_COUNT_L2'(0);
      write_value1 = `BIT_WIDTH'(0);
    end
  end

  // circular queue storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= QCNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i]  <= `REG_COUNT_L2'(0);
        value_r[i] <= `BIT_WIDTH'(0);
      end
    end else if (flush) begin
      head_r  <= PTR_W'(0);
      tail_r  <= PTR_W'(0);
      count_r <= QCNT_W'(0);
    end else begin
      if (push_s) begin
        addr_r[tail_r]  <= wb_addr;
        value_r[tail_r] <= wb_value;
        tail_r          <= tail_r + PTR_W'(1);
      end
      if (drain_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, drain_s})
        2'b10:   count_r <= count_r + QCNT_W'(1);
        2'b01:   count_r <= count_r - QCNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // per-register increment/decrement decode and pending view
  always_comb begin
    for (int i = 0; i < `REG_COUNT; i++) begin
      inc_s[i]     = reserve_valid && !flush && (reserve_addr == `REG_COUNT_L2'(i));
      dec_s[i]     = drain_s && !flush && (head_addr_s == `REG_COUNT_L2'(i));
      inc_err_s[i] = inc_s[i] && !dec_s[i] && (cnt_r[i] == CNT_MAX);
      dec_err_s[i] = dec_s[i] && !inc_s[i] && (cnt_r[i] == CNT_W'(0));
      pending[i]   = (cnt_r[i] != CNT_W'(0));
    end
  end

  // outstanding-write counters; saturate at max, hold at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < `REG_COUNT; i++) cnt_r[i] <= CNT_W'(0);
    end else if (flush) begin
      for (int i = 0; i < `REG_COUNT; i++) cnt_r[i] <= CNT_W'(0);
    end else begin
      for (int i = 0; i < `REG_COUNT; i++) begin
        if (inc_s[i] && !dec_s[i] && !inc_err_s[i]) cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        else if (dec_s[i] && !inc_s[i] && !dec_err_s[i]) cnt_r[i] <= cnt_r[i] - CNT_W'(1);
        else cnt_r[i] <= cnt_r[i];
      end
    end
  end

`ifdef REGFILE_WRITER_BYPASS_EN
  // scan oldest to youngest so the youngest match wins
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_value = `BIT_WIDTH'(0);
    for (int k = 0; k < DEPTH; k++) begin
      if ((QCNT_W'(k) < count_r) && (addr_r[head_r + PTR_W'(k)] == fwd_addr)) begin
        fwd_hit   = 1'b1;
        fwd_value = value_r[head_r + PTR_W'(k)];
      end else begin
        fwd_hit   = fwd_hit;
        fwd_value = fwd_value;
      end
    end
  end
`else
  logic unused_fwd_addr_s;
  assign unused_fwd_addr_s = ^fwd_addr;
  assign fwd_hit   = 1'b0;
  assign fwd_value = `BIT_WIDTH'(0);
`endif

`ifndef SYNTHESIS
  regfile_writer_chk #(.N(`REG_COUNT)) u_chk (
    .clk     (clk),
    .reset   (reset),
    .inc_err (inc_err_s),
    .dec_err (dec_err_s)
  );
`endif

endmodule
